// File: rtl/mem_responder.sv
// Byte-addressed load/store memory with a fixed access latency.
// One request in flight; response held until the requester takes it.
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic [7:0] r_mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [7:0]            w_b3;
  logic                  w_legal;
  logic                  w_misal;
  logic                  w_oob;
  logic                  w_err;
  logic                  w_access;
  logic [DATA_WIDTH-1:0] w_load;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_idx    = r_addr[ADDR_WIDTH-1:0];
  assign w_access = !rst && (r_state == S_WAIT) && (r_cnt == '0);

  assign w_b0 = r_mem[w_idx];
  assign w_b1 = r_mem[w_idx + ADDR_WIDTH'(1)];
  assign w_b2 = r_mem[w_idx + ADDR_WIDTH'(2)];
  assign w_b3 = r_mem[w_idx + ADDR_WIDTH'(3)];

  always_comb begin
    w_legal = 1'b0;
    if (r_we) begin
      w_legal = (r_f3 == 3'b000) || (r_f3 == 3'b001)
             || (r_f3 == 3'b010);
    end else begin
      w_legal = (r_f3 == 3'b000) || (r_f3 == 3'b001)
             || (r_f3 == 3'b010) || (r_f3 == 3'b100)
             || (r_f3 == 3'b101);
    end
  end

  assign w_misal = ((r_f3[1:0] == 2'b01) && r_addr[0])
                || ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_oob   = (r_addr >> ADDR_WIDTH) != '0;
  assign w_err   = !w_legal || w_misal || w_oob;

  // LB/LH sign-extend through the signed cast; LBU/LHU zero-extend
  always_comb begin
    w_load = '0;
    unique case (r_f3)
      3'b000:  w_load = DATA_WIDTH'($signed(w_b0));
      3'b001:  w_load = DATA_WIDTH'($signed({w_b1, w_b0}));
      3'b010:  w_load = DATA_WIDTH'({w_b3, w_b2, w_b1, w_b0});
      3'b100:  w_load = DATA_WIDTH'(w_b0);
      3'b101:  w_load = DATA_WIDTH'({w_b1, w_b0});
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_f3    <= req_funct3;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == S_WAIT) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_err   <= w_err;
          r_rdata <= (w_err || r_we) ? '0 : w_load;
        end
      end
    end
  end

  // Storage has no reset; it only changes on the access edge
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_err) begin
      r_mem[w_idx] <= r_wdata[7:0];
      if (r_f3[1:0] != 2'b00) begin
        r_mem[w_idx + ADDR_WIDTH'(1)] <= r_wdata[15:8];
      end
      if (r_f3[1:0] == 2'b10) begin
        r_mem[w_idx + ADDR_WIDTH'(2)] <= r_wdata[23:16];
        r_mem[w_idx + ADDR_WIDTH'(3)] <= r_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed cases plus a randomized
// load/store mix checked against a byte-array memory model.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;

  byte unsigned m_mem [int unsigned];

  mem_responder #(.LATENCY(2)) u_dut0 (
    .clk        (clk),
    .rst        (rst[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .req_funct3 (req_funct3[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  mem_responder #(.LATENCY(3)) u_dut1 (
    .clk        (clk),
    .rst        (rst[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .req_funct3 (req_funct3[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  // Reference: byte array, size from funct3, arithmetic extension
  function automatic void model(
    input  int          d,
    input  bit          we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  f3,
    output logic [31:0] rd,
    output logic        er
  );
    int unsigned sz;
    bit          legal;
    logic [31:0] v;
    int unsigned k;
    sz = 1 << f3[1:0];
    v  = '0;
    if (we) legal = (f3 <= 3'd2);
    else legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    er = !legal || (a % sz != 0) || (a >= 32'h2_0000);
    rd = '0;
    if (er) return;
    for (int i = 0; i < int'(sz); i++) begin
      k = int'(d) * 32'h10_0000 + a + i;
      if (we) m_mem[k] = wd[8*i +: 8];
      else v = v | (32'(m_mem[k]) << (8 * i));
    end
    if (!we && !f3[2] && sz < 4 && v[8*sz-1])
      v = v | (32'hFFFF_FFFF << (8 * sz));
    if (!we) rd = v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input int          d,
    input bit          we,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [2:0]  f3
  );
    int n = 0;
    while (!req_ready[d] && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: got %b want 1", req_ready[d]);
    end
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    req_funct3[d] = f3;
    tick();
    // garbage that must be ignored outside IDLE
    req_valid[d]  = 1'b1;
    req_we[d]     = 1'($urandom_range(0, 1));
    req_addr[d]   = $urandom_range(0, 255);
    req_wdata[d]  = $urandom;
    req_funct3[d] = 3'($urandom_range(0, 7));
  endtask

  task automatic do_req(
    input  int          d,
    input  bit          we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  f3,
    input  int          hold,
    output int          lat,
    output logic [31:0] rd,
    output logic        er,
    output bit          stable,
    output bit          idle_ok
  );
    issue(d, we, a, wd, f3);
    resp_ready[d] = 1'b1;
    lat = 0;
    while (!resp_valid[d] && lat < 50) begin
      tick();
      lat++;
    end
    rd = resp_rdata[d];
    er = resp_err[d];
    stable = 1'b1;
    resp_ready[d] = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!resp_valid[d] || req_ready[d]
          || resp_rdata[d] !== rd || resp_err[d] !== er)
        stable = 1'b0;
    end
    resp_ready[d] = 1'b1;
    tick();
    idle_ok = req_ready[d] && !resp_valid[d];
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d] = 1'b0;
      req_addr[d] = '0;
      req_wdata[d] = '0;
      req_funct3[d] = '0;
      resp_ready[d] = 1'b0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0
          || resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset%0d: got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                 d, req_ready[d], resp_valid[d],
                 resp_rdata[d], resp_err[d]);
      end
    end
  endtask

  task automatic test_word();
    int lat;
    logic [31:0] rd;
    logic er;
    bit st, ok;
    do_req(0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0, lat, rd, er, st, ok);
    checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0 || !ok) begin
      errors++;
      $display("FAIL sw: got lat=%0d err=%b rd=%h idle=%b want 2 0 0 1",
               lat, er, rd, ok);
    end
    do_req(0, 0, 32'h100, 32'h0, 3'b010, 0, lat, rd, er, st, ok);
    checks++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw: got lat=%0d err=%b rd=%h want 2 0 deadbeef",
               lat, er, rd);
    end
  endtask

  task automatic test_subword();
    logic [31:0] ad [6] = '{32'h103, 32'h103, 32'h102,
                            32'h100, 32'h101, 32'h102};
    logic [2:0]  fn [6] = '{3'b000, 3'b100, 3'b001,
                            3'b101, 3'b000, 3'b101};
    logic [31:0] ex [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                            32'h0000BEEF, 32'hFFFFFFBE, 32'h0000DEAD};
    int lat;
    logic [31:0] rd;
    logic er;
    bit st, ok;
    for (int i = 0; i < 6; i++) begin
      do_req(0, 0, ad[i], 32'h0, fn[i], 0, lat, rd, er, st, ok);
      checks++;
      if (er !== 1'b0 || rd !== ex[i]) begin
        errors++;
        $display("FAIL subword%0d: got err=%b rd=%h want 0 %h",
                 i, er, rd, ex[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    int lat;
    logic [31:0] rd;
    logic er;
    bit st, ok;
    do_req(0, 1, 32'h101, 32'h12345677, 3'b000, 0, lat, rd, er, st, ok);
    do_req(0, 0, 32'h100, 32'h0, 3'b010, 0, lat, rd, er, st, ok);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEAD77EF) begin
      errors++;
      $display("FAIL sb: got err=%b rd=%h want 0 dead77ef", er, rd);
    end
  endtask

  task automatic test_errors();
    bit          we [5] = '{0, 1, 0, 0, 1};
    logic [31:0] ad [5] = '{32'h102, 32'h101, 32'h100,
                            32'h0002_0000, 32'h100};
    logic [2:0]  fn [5] = '{3'b010, 3'b001, 3'b011,
                            3'b010, 3'b100};
    int lat;
    logic [31:0] rd;
    logic er;
    bit st, ok;
    for (int i = 0; i < 5; i++) begin
      do_req(0, we[i], ad[i], 32'hFFFF_FFFF, fn[i], 0,
             lat, rd, er, st, ok);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL err%0d: got err=%b rd=%h want 1 0", i, er, rd);
      end
    end
    do_req(0, 0, 32'h100, 32'h0, 3'b010, 0, lat, rd, er, st, ok);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEAD77EF) begin
      errors++;
      $display("FAIL err_nowrite: got err=%b rd=%h want 0 dead77ef",
               er, rd);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] rd;
    logic er;
    bit st, ok;
    do_req(0, 0, 32'h100, 32'h0, 3'b010, 5, lat, rd, er, st, ok);
    checks++;
    if (!st || !ok || rd !== 32'hDEAD77EF) begin
      errors++;
      $display("FAIL backpressure: got stable=%b idle=%b rd=%h want 1 1 dead77ef",
               st, ok, rd);
    end
  endtask

  task automatic test_reset_wait();
    int lat, n;
    logic [31:0] rd;
    logic er;
    bit st, ok;
    do_req(1, 1, 32'h200, 32'hA5A5A5A5, 3'b010, 0, lat, rd, er, st, ok);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL lat3: got %0d want 3", lat);
    end
    issue(1, 1, 32'h200, 32'h55, 3'b010);
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    st = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!req_ready[1] || resp_valid[1]) st = 1'b0;
      tick();
    end
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL rst_wait_idle: got stable=0 want 1");
    end
    do_req(1, 0, 32'h200, 32'h0, 3'b010, 0, lat, rd, er, st, ok);
    checks++;
    if (er !== 1'b0 || rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rst_wait_mem: got err=%b rd=%h want 0 a5a5a5a5",
               er, rd);
    end
    issue(1, 1, 32'h204, 32'h11223344, 3'b010);
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    n = 0;
    while (!resp_valid[1] && n < 50) begin
      tick();
      n++;
    end
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    checks++;
    if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || n != 3) begin
      errors++;
      $display("FAIL rst_resp: got vld=%b rdy=%b lat=%0d want 0 1 3",
               resp_valid[1], req_ready[1], n);
    end
    do_req(1, 0, 32'h204, 32'h0, 3'b010, 0, lat, rd, er, st, ok);
    checks++;
    if (er !== 1'b0 || rd !== 32'h11223344) begin
      errors++;
      $display("FAIL rst_resp_mem: got err=%b rd=%h want 0 11223344",
               er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    bit r;
    int n;
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_addr[0]   = 32'h100;
    req_funct3[0] = 3'b010;
    resp_ready[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      r = req_ready[0];
      tick();
      if (r) acc.push_back(i);
    end
    req_valid[0] = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      tick();
      n++;
    end
    resp_ready[0] = 1'b0;
    checks++;
    if (acc.size() < 2 || acc[1] - acc[0] != 4) begin
      errors++;
      $display("FAIL back_to_back: got %0d accepts spacing %0d want 4",
               acc.size(), acc.size() < 2 ? 0 : acc[1] - acc[0]);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] rd, erd, a, wd;
    logic er, eer;
    logic [2:0] f3;
    bit st, ok, we;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model(0, 1, 32'(w * 4), wd, 3'b010, erd, eer);
      do_req(0, 1, 32'(w * 4), wd, 3'b010, 0, lat, rd, er, st, ok);
    end
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0)
        a = a + 32'h2_0000 * $urandom_range(1, 3);
      wd = $urandom;
      model(0, we, a, wd, f3, erd, eer);
      do_req(0, we, a, wd, f3, $urandom_range(0, 2),
             lat, rd, er, st, ok);
      checks++;
      if (lat != 2 || rd !== erd || er !== eer || !ok) begin
        errors++;
        $display("FAIL rand%0d we=%b a=%h f3=%b: got lat=%0d rd=%h err=%b want 2 %h %b",
                 i, we, a, f3, lat, rd, er, erd, eer);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
